// File: rtl/sram_write_packer_pkg.sv
// rtl/sram_write_packer_pkg.sv - shared widths, word size and FSM encoding for the SRAM write packer
package sram_write_packer_pkg;

    localparam int MAX_ADDR_WIDTH = 16;
    localparam int INT8_SIZE      = 8;
    localparam int INT32_SIZE     = 32;
    localparam int WORD_BYTES     = 8;

    typedef enum logic [1:0] {
        WP_IDLE  = 2'd0,
        WP_RUN   = 2'd1,
        WP_FLUSH = 2'd2,
        WP_DONE  = 2'd3
    } wp_state_e;

endpackage

// File: rtl/sram_write_packer_buffer.sv
// rtl/sram_write_packer_buffer.sv - staging byte buffer with simultaneous word shift-out and vector append
module write_pack_buffer #(
    parameter int LANES  = 8,
    parameter int BYTES  = 16,
    parameter int BYTE_W = 8,
    parameter int FILL_W = $clog2(BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    shift_en,
    input  logic                    append_en,
    input  logic [3:0]              append_cnt,
    input  logic [LANES*BYTE_W-1:0] append_data,
    output logic [FILL_W-1:0]       fill_next,
    output logic [LANES*BYTE_W-1:0] word
);

    localparam int SEL_W = $clog2(LANES);

    logic [BYTE_W-1:0] mem_q [BYTES];
    logic [BYTE_W-1:0] mem_s [BYTES];
    logic [BYTE_W-1:0] mem_n [BYTES];
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_s;
    logic [FILL_W-1:0] idx;

    // Bytes at or above fill are always zero, so a partial word needs no extra masking of data.
    always_comb begin
        fill_s = fill_q;
        idx    = '0;
        for (int i = 0; i < BYTES; i++) mem_s[i] = mem_q[i];
        if (shift_en) begin
            if (fill_q >= FILL_W'(LANES)) begin
                fill_s = fill_q - FILL_W'(LANES);
                for (int i = 0; i < BYTES - LANES; i++) mem_s[i] = mem_q[i + LANES];
                for (int i = BYTES - LANES; i < BYTES; i++) mem_s[i] = '0;
            end else begin
                fill_s = '0;
                for (int i = 0; i < BYTES; i++) mem_s[i] = '0;
            end
        end

        fill_next = fill_s;
        for (int i = 0; i < BYTES; i++) mem_n[i] = mem_s[i];
        if (append_en) begin
            fill_next = fill_s + FILL_W'(append_cnt);
            for (int i = 0; i < BYTES; i++) begin
                idx = FILL_W'(i) - fill_s;
                if (FILL_W'(i) >= fill_s && FILL_W'(i) < fill_next)
                    mem_n[i] = append_data[idx[SEL_W-1:0]*BYTE_W +: BYTE_W];
            end
        end

        if (clear) begin
            fill_next = '0;
            for (int i = 0; i < BYTES; i++) mem_n[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fill_q <= '0;
            for (int i = 0; i < BYTES; i++) mem_q[i] <= '0;
        end else begin
            fill_q <= fill_next;
            for (int i = 0; i < BYTES; i++) mem_q[i] <= mem_n[i];
        end
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) word[k*BYTE_W +: BYTE_W] = mem_q[k];
    end

endmodule

// File: rtl/sram_write_packer.sv
// rtl/sram_write_packer.sv - packs int8 result vectors into byte-masked SRAM words; WRITE_PACKER_PERF_EN adds a stall counter
module sram_write_packer
    import sram_write_packer_pkg::*;
#(
    parameter int MAX_VECTOR_SIZE = 8,
    parameter int BUF_BYTES       = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 init,
    input  logic                                 start_i,
    input  logic [MAX_ADDR_WIDTH-1:0]            base_addr_i,
    input  logic [INT32_SIZE-1:0]                number_of_elements_i,
    input  logic                                 valid_i,
    input  logic [3:0]                           lane_cnt_i,
    input  logic [MAX_VECTOR_SIZE*INT8_SIZE-1:0] data_i,
    output logic                                 ready_o,
    output logic                                 wr_en_o,
    input  logic                                 wr_ready_i,
    output logic [MAX_ADDR_WIDTH-1:0]            wr_addr_o,
    output logic [MAX_VECTOR_SIZE*INT8_SIZE-1:0] wr_data_o,
    output logic [MAX_VECTOR_SIZE-1:0]           wr_mask_o,
    output logic                                 done_o
`ifdef WRITE_PACKER_PERF_EN
    ,
    output logic [INT32_SIZE-1:0]                stall_cnt_o
`endif
);

    localparam int FILL_W = $clog2(BUF_BYTES + 1);

    wp_state_e                  state_q, state_n;
    logic [INT32_SIZE-1:0]      remaining_q, remaining_n;
    logic [MAX_ADDR_WIDTH-1:0]  addr_q, addr_n;
    logic [3:0]                 lanes, accept_cnt;
    logic                       in_xfer, wr_xfer, start_accept;
    logic [FILL_W-1:0]          fill_next;
    logic                       ready_n, wr_en_n, done_n;
    logic [MAX_VECTOR_SIZE-1:0] wr_mask_n;

    assign in_xfer = valid_i & ready_o;
    assign wr_xfer = wr_en_o & wr_ready_i;

    always_comb begin
        lanes = lane_cnt_i;
        if (lane_cnt_i == 4'd0 || lane_cnt_i > 4'(MAX_VECTOR_SIZE)) lanes = 4'(MAX_VECTOR_SIZE);
        accept_cnt = (remaining_q < INT32_SIZE'(lanes)) ? remaining_q[3:0] : lanes;
    end

    write_pack_buffer #(
        .LANES  (MAX_VECTOR_SIZE),
        .BYTES  (BUF_BYTES),
        .BYTE_W (INT8_SIZE),
        .FILL_W (FILL_W)
    ) u_buffer (
        .clk         (clk),
        .rst         (rst),
        .clear       (init | start_accept),
        .shift_en    (wr_xfer),
        .append_en   (in_xfer),
        .append_cnt  (accept_cnt),
        .append_data (data_i),
        .fill_next   (fill_next),
        .word        (wr_data_o)
    );

    always_comb begin
        state_n      = state_q;
        remaining_n  = remaining_q;
        addr_n       = addr_q;
        start_accept = 1'b0;
        if (wr_xfer) addr_n = addr_q + MAX_ADDR_WIDTH'(WORD_BYTES);
        case (state_q)
            WP_IDLE: begin
                if (start_i) begin
                    start_accept = 1'b1;
                    if (number_of_elements_i != '0) begin
                        state_n     = WP_RUN;
                        remaining_n = number_of_elements_i;
                        addr_n      = base_addr_i;
                    end else begin
                        state_n = WP_DONE;
                    end
                end
            end
            WP_RUN: begin
                if (in_xfer) begin
                    remaining_n = remaining_q - INT32_SIZE'(accept_cnt);
                    if (remaining_n == '0) state_n = WP_FLUSH;
                end
            end
            WP_FLUSH: if (fill_next == '0) state_n = WP_DONE;
            WP_DONE:  state_n = WP_IDLE;
            default:  state_n = WP_IDLE;
        endcase

        // Outputs are decoded from the next state so every port leaves a flop.
        ready_n = (state_n == WP_RUN) && (fill_next <= FILL_W'(MAX_VECTOR_SIZE));
        wr_en_n = ((state_n == WP_RUN) && (fill_next >= FILL_W'(MAX_VECTOR_SIZE))) ||
                  ((state_n == WP_FLUSH) && (fill_next != '0));
        done_n  = (state_n == WP_DONE);
        for (int k = 0; k < MAX_VECTOR_SIZE; k++)
            wr_mask_n[k] = wr_en_n && (fill_next > FILL_W'(k));
    end

    always_ff @(posedge clk) begin
        if (!rst || init) begin
            state_q     <= WP_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            ready_o     <= 1'b0;
            wr_en_o     <= 1'b0;
            wr_mask_o   <= '0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_n;
            remaining_q <= remaining_n;
            addr_q      <= addr_n;
            ready_o     <= ready_n;
            wr_en_o     <= wr_en_n;
            wr_mask_o   <= wr_mask_n;
            done_o      <= done_n;
        end
    end

    assign wr_addr_o = addr_q;

`ifdef WRITE_PACKER_PERF_EN
    logic [INT32_SIZE-1:0] word_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst || init || (state_q == WP_IDLE && start_i)) begin
            stall_cnt_o <= '0;
            word_cnt_q  <= '0;
        end else begin
            if (wr_en_o && !wr_ready_i && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
            if (wr_xfer) word_cnt_q <= word_cnt_q + 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && !init && state_q == WP_DONE)
            $display("sram_write_packer: words=%0d stalls=%0d", word_cnt_q, stall_cnt_o);
    end
`endif
`endif

endmodule

// File: tb/tb_sram_write_packer.sv
// tb/tb_sram_write_packer.sv - directed and randomized checks of sram_write_packer against a byte-queue model
module tb_sram_write_packer;
    import sram_write_packer_pkg::*;

    logic        clk = 1'b0;
    logic        rst, init, start_i, valid_i, wr_ready_i;
    logic [15:0] base_addr_i;
    logic [31:0] number_of_elements_i;
    logic [3:0]  lane_cnt_i;
    logic [63:0] data_i;
    logic        ready_o, wr_en_o, done_o;
    logic [15:0] wr_addr_o;
    logic [63:0] wr_data_o;
    logic [7:0]  wr_mask_o;
`ifdef WRITE_PACKER_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    always #5 clk = ~clk;

    sram_write_packer dut (
        .clk                  (clk),
        .rst                  (rst),
        .init                 (init),
        .start_i              (start_i),
        .base_addr_i          (base_addr_i),
        .number_of_elements_i (number_of_elements_i),
        .valid_i              (valid_i),
        .lane_cnt_i           (lane_cnt_i),
        .data_i               (data_i),
        .ready_o              (ready_o),
        .wr_en_o              (wr_en_o),
        .wr_ready_i           (wr_ready_i),
        .wr_addr_o            (wr_addr_o),
        .wr_data_o            (wr_data_o),
        .wr_mask_o            (wr_mask_o),
        .done_o               (done_o)
`ifdef WRITE_PACKER_PERF_EN
        ,
        .stall_cnt_o          (stall_cnt_o)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Model: bytes accepted but not yet written, in stream order.
    logic [7:0]  exp_q[$];
    logic        model_active = 1'b0;
    logic [31:0] model_rem    = '0;
    logic [15:0] model_base   = '0;
    int          model_words  = 0;
    logic        exp_done     = 1'b0;
    int          rdy_mode     = 0;
    int          done_pulses  = 0;
    logic        last_in_xfer = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        in_x, wr_x, done_nx;
        int          n, lcn, acc;
        logic [63:0] ed;
        logic [7:0]  em;
        logic [15:0] ea;
        case (rdy_mode)
            0:       wr_ready_i = 1'b1;
            1:       wr_ready_i = 1'($urandom_range(0, 1));
            default: wr_ready_i = 1'b0;
        endcase

        chk("ready", ready_o, model_active && model_rem != 0 && exp_q.size() <= 8);
        chk("wr_en", wr_en_o, model_active && (exp_q.size() >= 8 || (model_rem == 0 && exp_q.size() > 0)));
        chk("done", done_o, exp_done);
        if (done_o) done_pulses++;
        n = (exp_q.size() >= 8) ? 8 : exp_q.size();
        if (wr_en_o) begin
            ed = '0;
            em = '0;
            for (int k = 0; k < n; k++) begin
                ed[k*8 +: 8] = exp_q[k];
                em[k] = 1'b1;
            end
            ea = model_base + 16'(8 * model_words);
            chk("wr_addr", wr_addr_o, ea);
            chk("wr_mask", wr_mask_o, em);
            chk("wr_data", wr_data_o, ed);
        end

        in_x = valid_i && ready_o;
        wr_x = wr_en_o && wr_ready_i;
        last_in_xfer = in_x;
        done_nx = 1'b0;
        if (init) begin
            model_active = 1'b0;
            exp_q.delete();
        end else begin
            if (wr_x && model_active) begin
                repeat (n) void'(exp_q.pop_front());
                model_words++;
                if (model_rem == 0 && exp_q.size() == 0) begin
                    model_active = 1'b0;
                    done_nx = 1'b1;
                end
            end
            if (in_x && model_active) begin
                lcn = (lane_cnt_i == 0 || lane_cnt_i > 8) ? 8 : int'(lane_cnt_i);
                acc = (model_rem < 32'(lcn)) ? int'(model_rem) : lcn;
                for (int m = 0; m < acc; m++) exp_q.push_back(data_i[m*8 +: 8]);
                model_rem = model_rem - 32'(acc);
            end
            if (start_i && !model_active && !exp_done) begin
                if (number_of_elements_i != 0) begin
                    model_active = 1'b1;
                    model_rem    = number_of_elements_i;
                    model_base   = base_addr_i;
                    model_words  = 0;
                end else begin
                    done_nx = 1'b1;
                end
            end
        end
        exp_done = done_nx;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input logic [15:0] base, input logic [31:0] n);
        base_addr_i          = base;
        number_of_elements_i = n;
        start_i              = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_vec(input logic [3:0] lc, input logic [63:0] d);
        int b = 0;
        valid_i    = 1'b1;
        lane_cnt_i = lc;
        data_i     = d;
        do begin
            tick();
            b++;
        end while (!last_in_xfer && b < 200);
        if (!last_in_xfer) begin
            errors++;
            $error("FAIL send_timeout: observed no accept expected accept within 200 cycles");
        end
        valid_i = 1'b0;
    endtask

    task automatic finish_txn();
        int b = 0;
        valid_i = 1'b0;
        while ((model_active || exp_done) && b < 500) begin
            tick();
            b++;
        end
        if (model_active || exp_done) begin
            errors++;
            $error("FAIL done_timeout: observed busy expected done within 500 cycles");
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        rst = 1'b0; init = 1'b0; start_i = 1'b0; valid_i = 1'b0; wr_ready_i = 1'b1;
        base_addr_i = '0; number_of_elements_i = '0; lane_cnt_i = '0; data_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", ready_o, 1'b0);
        chk("rst_wr_en", wr_en_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_addr", wr_addr_o, 16'h0);
        chk("rst_data", wr_data_o, 64'h0);
        chk("rst_mask", wr_mask_o, 8'h0);
        rst = 1'b1;
        tick();

        // Two full vectors, exact fit of two words.
        done_pulses = 0;
        do_start(16'h0040, 16);
        send_vec(4'd8, 64'h0706050403020100);
        send_vec(4'd8, 64'h0F0E0D0C0B0A0908);
        finish_txn();
        chk("t1_done_once", done_pulses, 1);

        // Partial last word, extra lanes discarded.
        do_start(16'h0000, 20);
        for (int v = 0; v < 3; v++) send_vec(4'd8, rand64());
        finish_txn();

        // Three-lane vectors, nine bytes.
        do_start(16'h0123, 9);
        for (int v = 0; v < 3; v++)
            send_vec(4'd3, {40'h0, 8'(3*v+3), 8'(3*v+2), 8'(3*v+1)});
        chk("t3_ready_low", ready_o, 1'b0);
        finish_txn();

        // Backpressure: write port stalled for five cycles with a vector waiting.
        do_start(16'h0080, 32);
        rdy_mode = 2;
        send_vec(4'd8, rand64());
        send_vec(4'd8, rand64());
        valid_i = 1'b1; lane_cnt_i = 4'd8; data_i = rand64();
        repeat (5) tick();
        chk("t4_ready_full", ready_o, 1'b0);
        rdy_mode = 0;
        send_vec(4'd8, data_i);
        send_vec(4'd8, rand64());
        finish_txn();

        // init in the middle of a run, then a clean restart.
        done_pulses = 0;
        do_start(16'h0010, 32);
        send_vec(4'd8, rand64());
        send_vec(4'd4, rand64());
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("t5_wr_en", wr_en_o, 1'b0);
        chk("t5_ready", ready_o, 1'b0);
        repeat (3) tick();
        chk("t5_no_done", done_pulses, 0);
        do_start(16'h0020, 8);
        send_vec(4'd8, rand64());
        finish_txn();

        // Zero-length job.
        done_pulses = 0;
        do_start(16'h0055, 0);
        finish_txn();
        repeat (3) tick();
        chk("t6_done_once", done_pulses, 1);

        // start_i during RUN is ignored.
        do_start(16'h0200, 24);
        send_vec(4'd8, rand64());
        do_start(16'h0300, 4);
        send_vec(4'd8, rand64());
        send_vec(4'd8, rand64());
        finish_txn();

        // Randomized jobs with odd lane counts, gaps, stalls and an address wrap.
        rdy_mode = 1;
        for (int t = 0; t < 8; t++) begin
            logic [15:0] b;
            b = (t == 0) ? 16'hFFF4 : 16'($urandom());
            do_start(b, 32'($urandom_range(1, 40)));
            while (model_active && model_rem != 0) begin
                if ($urandom_range(0, 3) == 0) tick();
                send_vec(4'($urandom_range(0, 15)), rand64());
            end
            finish_txn();
        end
        rdy_mode = 0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
